// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// The state encodings live here once and are imported by the RTL and the bench.
package mux2_rr_arbiter_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwnA = 2'd1,
    StOwnB = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Request/grant and data bundle between two requesters and the shared output path.
interface mux2_rr_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             gnt_a;
  logic             gnt_b;
  logic             S;
  logic             E;
  logic [WIDTH-1:0] Y;

  modport master (
    output req_a, req_b, A, B,
    input  gnt_a, gnt_b, S, E, Y
  );

  modport slave (
    input  req_a, req_b, A, B,
    output gnt_a, gnt_b, S, E, Y
  );
endinterface

// File: rtl/mux_quad_2x1.sv
// WIDTH-bit 2:1 multiplexer with active-low enable; disabled output is zero.
module mux_quad_2x1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             s_i,
  input  logic             en_ni,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (!en_ni) begin
      y_o = s_i ? b_i : a_i;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter granting one of two requesters the shared output mux,
// with a bounded tenure of HOLD cycles before yielding to a waiting peer.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 3
) (
  input logic              clk,
  input logic              rst,
  mux2_rr_arbiter_if.slave bus
);

  localparam logic [CntW-1:0] HoldLd = CntW'(HOLD - 1);

  arb_state_e      state_q, state_d;
  logic            ptr_q, ptr_d;   // last owner: 0 = A, 1 = B
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            s_q, s_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (bus.req_a && bus.req_b) begin
          state_d = ptr_q ? StOwnA : StOwnB;
        end else if (bus.req_a) begin
          state_d = StOwnA;
        end else if (bus.req_b) begin
          state_d = StOwnB;
        end
      end
      StOwnA: begin
        if (!bus.req_a) begin
          state_d = bus.req_b ? StOwnB : StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus.req_b) begin
          state_d = StOwnB;
        end else begin
          cnt_d = HoldLd;
        end
      end
      StOwnB: begin
        if (!bus.req_b) begin
          state_d = bus.req_a ? StOwnA : StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus.req_a) begin
          state_d = StOwnA;
        end else begin
          cnt_d = HoldLd;
        end
      end
      default: state_d = StIdle;
    endcase

    // Any entry into an ownership state starts a fresh tenure.
    if (state_d != state_q && state_d != StIdle) begin
      cnt_d = HoldLd;
      ptr_d = (state_d == StOwnB);
    end

    s_d = s_q;
    if (state_d == StOwnA) begin
      s_d = 1'b0;
    end else if (state_d == StOwnB) begin
      s_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
    end
  end

  // Decoded straight from the state flop so grants never see req combinationally.
  assign bus.gnt_a = (state_q == StOwnA);
  assign bus.gnt_b = (state_q == StOwnB);
  assign bus.E     = (state_q == StIdle);
  assign bus.S     = s_q;

  mux_quad_2x1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a_i  (bus.A),
    .b_i  (bus.B),
    .s_i  (s_q),
    .en_ni(bus.E),
    .y_o  (bus.Y)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter with WIDTH=4, HOLD=3.
module tb_mux2_rr_arbiter;
  import mux2_rr_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux2_rr_arbiter_if #(.WIDTH(4)) bus ();

  mux2_rr_arbiter #(
    .WIDTH(4),
    .HOLD (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_s);
    check_eq({tag, " gnt_a"}, 32'(bus.gnt_a), 32'd0);
    check_eq({tag, " gnt_b"}, 32'(bus.gnt_b), 32'd0);
    check_eq({tag, " E"}, 32'(bus.E), 32'd1);
    check_eq({tag, " Y"}, 32'(bus.Y), 32'd0);
    check_eq({tag, " S"}, 32'(bus.S), 32'(exp_s));
  endtask

  task automatic check_own(input string tag, input arb_state_e own, input logic [3:0] exp_y);
    check_eq({tag, " gnt_a"}, 32'(bus.gnt_a), 32'(own == StOwnA));
    check_eq({tag, " gnt_b"}, 32'(bus.gnt_b), 32'(own == StOwnB));
    check_eq({tag, " S"}, 32'(bus.S), 32'(own == StOwnB));
    check_eq({tag, " E"}, 32'(bus.E), 32'd0);
    check_eq({tag, " Y"}, 32'(bus.Y), 32'(exp_y));
  endtask

  // Owner after each edge with both requesting from reset, HOLD=3.
  arb_state_e contend_tbl [12] = '{StOwnA, StOwnA, StOwnA, StOwnB, StOwnB, StOwnB,
                                   StOwnA, StOwnA, StOwnA, StOwnB, StOwnB, StOwnB};

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.A     = 4'd5;
    bus.B     = 4'd10;

    // Asynchronous reset, observed before the first clock edge.
    #2 rst = 1'b1;
    #1 check_idle("reset_async", 1'b0);
    @(negedge clk);
    check_idle("reset_held", 1'b0);

    // Single requester A; tenure reloads without an idle gap.
    bus.req_b = 1'b0;
    bus.A     = 4'd15;
    rst       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_own($sformatf("single_a[%0d]", i), StOwnA, 4'd15);
    end
    bus.req_a = 1'b0;
    @(negedge clk);
    check_idle("single_a_release", 1'b0);

    // Contention from a fresh reset: A first, switching every HOLD cycles.
    rst = 1'b1;
    #1 rst = 1'b0;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.A     = 4'd0;
    bus.B     = 4'd10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_own($sformatf("contend[%0d]", i), contend_tbl[i],
                (contend_tbl[i] == StOwnB) ? 4'd10 : 4'd0);
    end

    // Early release of A hands over to B in one edge.
    @(negedge clk);
    check_own("contend_wrap", StOwnA, 4'd0);
    bus.req_a = 1'b0;
    @(negedge clk);
    check_own("early_release", StOwnB, 4'd10);

    // Both drop: idle, S keeps B.
    bus.req_b = 1'b0;
    @(negedge clk);
    check_idle("both_drop", 1'b1);

    // Reset in the middle of a B tenure.
    bus.req_b = 1'b1;
    @(negedge clk);
    check_own("mid_b_enter", StOwnB, 4'd10);
    @(negedge clk);
    check_own("mid_b_cnt1", StOwnB, 4'd10);
    bus.req_a = 1'b1;
    bus.A     = 4'd5;
    rst       = 1'b1;
    #1 check_idle("mid_reset", 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_own("after_mid_reset", StOwnA, 4'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
